freq_step_ctrl: RTL and testbench
=================================

Name: freq_step_ctrl

Overview:
- Sequences the resonant-inverter frequency search.
- Owns the 20-bit `freq` word driven to the inverter and to the frequency tracker.
- After each frequency change it waits a settle time, then pulses `data_start` to restart the tracker's peak-current measurement. On `freq_ready` it steps `freq` in the commanded direction.
- Step size halves on every direction reversal. The block locks when the tracker reports an optimum or the step has converged.

Parameters:
- FREQ_W, 20, width of frequency word
- F_MIN, 20'd30000, lower clamp
- F_MAX, 20'd50000, upper clamp
- F_INIT, 20'd40000, start frequency after reset or disable
- STEP_INIT, 20'd200, initial step size
- STEP_MIN, 20'd10, smallest step
- SETTLE_CYC, 16'd2500, clk cycles of settle time after each freq change (>=1)
- REV_LIMIT, 4'd3, reversals at STEP_MIN that force lock
- TIMEOUT_CYC, 20'd100000, MEASURE watchdog (optional feature only)

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- enable  in  1  run search; low returns to IDLE
- freq_ready  in  1  1-cycle pulse from tracker, comparison done
- freq_set_up_down  in  1  tracker direction, 1 = increase freq
- freq_opt  in  1  tracker optimum flag, valid with freq_ready
- freq  out  FREQ_W  inverter frequency word
- data_start  out  1  1-cycle pulse, restart tracker measurement
- busy  out  1  state is SETTLE, MEASURE or STEP
- locked  out  1  state is LOCKED
- at_limit  out  1  last step was clamped to F_MIN/F_MAX
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (nrst=0 at posedge):
  - Outputs: freq=F_INIT, data_start=0, busy=0, locked=0, at_limit=0, timeout=0.
  - Internals: step=STEP_INIT, last_dir=1, rev_cnt=0, state=IDLE.
- IDLE:
  - Outputs: freq=F_INIT, step=STEP_INIT, rev_cnt=0, last_dir=1.
  - enable=1 -> SETTLE, with settle counter loaded SETTLE_CYC-1.
- SETTLE:
  - Counter decrements each cycle.
  - Cycle with counter==0: data_start=1, next state MEASURE.
  - SETTLE therefore lasts exactly SETTLE_CYC cycles.
  - freq_ready in SETTLE is ignored, because the measurement is stale.
- MEASURE: waits for freq_ready.
  - freq_ready && freq_opt -> LOCKED.
  - freq_ready && !freq_opt:
    - If freq_set_up_down != last_dir: step <= max(step>>1, STEP_MIN). rev_cnt increments only if the old step was already STEP_MIN, saturating at 15.
    - last_dir <= freq_set_up_down.
    - Next state STEP.
- STEP (one cycle):
  - nf = freq ± step, computed at FREQ_W+1 bits, no wrap.
  - Clamp nf to [F_MIN,F_MAX]; at_limit <= 1 if clamped, else 0.
  - freq <= clamped nf.
  - If rev_cnt >= REV_LIMIT -> LOCKED, with freq unchanged. Otherwise -> SETTLE, with the counter reloaded.
- LOCKED:
  - freq held, locked=1.
  - freq_ready && !freq_opt -> loss of lock: locked<=0, step<=STEP_INIT, rev_cnt<=0, then SETTLE from the current freq.
- Global rules:
  - enable=0 in any non-IDLE state -> IDLE next cycle. freq returns to F_INIT; data_start is not issued.
  - Reset mid-operation overrides everything.
  - data_start never asserts on two consecutive cycles.
  - freq changes only in STEP or on entry to IDLE.

Optional Feature:
- Macro: FREQ_STEP_CTRL_TIMEOUT_EN.
- Defined: a watchdog counter loads TIMEOUT_CYC-1 on MEASURE entry and decrements each MEASURE cycle. If it reaches 0 without freq_ready:
  - timeout <= 1 (sticky until reset or enable=0).
  - Next state SETTLE, so data_start is reissued, with freq unchanged.
- Undefined: no watchdog logic; timeout is tied 0; MEASURE waits indefinitely.

Test Plan:
- Reset: nrst=0 for 2 cycles -> freq=40000, data_start=0, busy=0, locked=0, at_limit=0, timeout=0.
- Settle timing: SETTLE_CYC=4, enable=1 -> busy=1 next cycle; data_start high exactly on the 4th SETTLE cycle, for 1 cycle; freq_ready pulsed during SETTLE has no effect.
- Stepping and halving: after each data_start, pulse freq_ready up=1, up=1, up=0, up=0 -> freq 40200, 40400, 40300, 40200 (step 200, 200, 100, 100).
- Clamp: F_INIT=49900, up=1 twice -> freq 50000 with at_limit=1, then still 50000 with at_limit=1; then up=0 -> 49900, at_limit=0.
- Lock and loss: freq_ready with freq_opt=1 -> locked=1, freq held across 3 further freq_opt=1 pulses. freq_ready with freq_opt=0 -> locked=0, step back to 200, data_start after SETTLE_CYC. enable=0 mid-SETTLE -> IDLE next cycle, freq=40000.
- Convergence and timeout: STEP_INIT=20, STEP_MIN=10, alternate up/down -> lock after 3 reversals at step 10. With macro and TIMEOUT_CYC=8, no freq_ready -> timeout=1 after 8 MEASURE cycles and data_start reissued.

Source files
------------

// File: rtl/freq_step_ctrl.sv
// rtl/freq_step_ctrl.sv - resonant-inverter frequency search sequencer
//
// Owns the inverter frequency word. After every frequency change it waits a
// settle time, pulses data_start to restart the tracker measurement, then
// steps freq in the direction the tracker reports. The step halves on each
// direction reversal; the block locks on a tracker optimum or once the step
// has converged at STEP_MIN for REV_LIMIT reversals.
//
// Optional build macro: FREQ_STEP_CTRL_TIMEOUT_EN adds a MEASURE watchdog
// (TIMEOUT_CYC) that sets the sticky timeout flag and reissues data_start.
//
// Ports:
//   clk              in   clock
//   nrst             in   synchronous active-low reset
//   enable           in   run search; low returns to IDLE
//   freq_ready       in   1-cycle pulse from tracker, comparison done
//   freq_set_up_down in   tracker direction, 1 = increase freq
//   freq_opt         in   tracker optimum flag, valid with freq_ready
//   freq             out  inverter frequency word
//   data_start       out  1-cycle pulse, restart tracker measurement
//   busy             out  state is SETTLE, MEASURE or STEP
//   locked           out  state is LOCKED
//   at_limit         out  last step was clamped to F_MIN/F_MAX
//   timeout          out  sticky watchdog flag (0 without the macro)

module freq_step_ctrl #(
    parameter int                FREQ_W      = 20,
    parameter logic [FREQ_W-1:0] F_MIN       = 20'd30000,
    parameter logic [FREQ_W-1:0] F_MAX       = 20'd50000,
    parameter logic [FREQ_W-1:0] F_INIT      = 20'd40000,
    parameter logic [FREQ_W-1:0] STEP_INIT   = 20'd200,
    parameter logic [FREQ_W-1:0] STEP_MIN    = 20'd10,
    parameter logic [15:0]       SETTLE_CYC  = 16'd2500,
    parameter logic [3:0]        REV_LIMIT   = 4'd3
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
    ,
    parameter logic [FREQ_W-1:0] TIMEOUT_CYC = 20'd100000
`endif
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              enable,
    input  logic              freq_ready,
    input  logic              freq_set_up_down,
    input  logic              freq_opt,
    output logic [FREQ_W-1:0] freq,
    output logic              data_start,
    output logic              busy,
    output logic              locked,
    output logic              at_limit,
    output logic              timeout
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_STEP    = 3'd3;
    localparam logic [2:0] ST_LOCKED  = 3'd4;

    localparam logic [15:0] SETTLE_LOAD = SETTLE_CYC - 16'd1;

    logic [2:0]        state_q, state_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [FREQ_W-1:0] step_q, step_d;
    logic              last_dir_q, last_dir_d;
    logic [3:0]        rev_cnt_q, rev_cnt_d;
    logic [15:0]       settle_cnt_q, settle_cnt_d;
    logic              at_limit_q, at_limit_d;
    logic              data_start_c;

`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
    localparam logic [FREQ_W-1:0] WD_LOAD = TIMEOUT_CYC - {{(FREQ_W-1){1'b0}}, 1'b1};
    logic [FREQ_W-1:0] wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    // Candidate next frequency, one bit wider so an up-step past the top of
    // the word range cannot wrap; a down-step below zero is flagged separately.
    logic [FREQ_W:0]   nf_sum;
    logic              nf_under;
    logic [FREQ_W-1:0] nf_clamped;
    logic              nf_hit_limit;
    logic [FREQ_W-1:0] step_half;
    logic [FREQ_W-1:0] step_rev;

    always_comb begin
        nf_sum       = '0;
        nf_under     = 1'b0;
        nf_clamped   = '0;
        nf_hit_limit = 1'b0;
        if (last_dir_q) begin
            nf_sum = {1'b0, freq_q} + {1'b0, step_q};
        end else begin
            nf_sum   = {1'b0, freq_q} - {1'b0, step_q};
            nf_under = (freq_q < step_q);
        end
        if (nf_under || (nf_sum < {1'b0, F_MIN})) begin
            nf_clamped   = F_MIN;
            nf_hit_limit = 1'b1;
        end else if (nf_sum > {1'b0, F_MAX}) begin
            nf_clamped   = F_MAX;
            nf_hit_limit = 1'b1;
        end else begin
            nf_clamped   = nf_sum[FREQ_W-1:0];
            nf_hit_limit = 1'b0;
        end
    end

    always_comb begin
        step_half = step_q >> 1;
        step_rev  = (step_half < STEP_MIN) ? STEP_MIN : step_half;
    end

    always_comb begin
        state_d      = state_q;
        freq_d       = freq_q;
        step_d       = step_q;
        last_dir_d   = last_dir_q;
        rev_cnt_d    = rev_cnt_q;
        settle_cnt_d = settle_cnt_q;
        at_limit_d   = at_limit_q;
        data_start_c = 1'b0;
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = timeout_q;
`endif

        if ((state_q != ST_IDLE) && !enable) begin
            // Dropping enable abandons the search; everything restarts from F_INIT.
            state_d    = ST_IDLE;
            freq_d     = F_INIT;
            step_d     = STEP_INIT;
            last_dir_d = 1'b1;
            rev_cnt_d  = 4'd0;
            at_limit_d = 1'b0;
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
            timeout_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    if (enable) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    // Any freq_ready arriving here belongs to a stale measurement.
                    if (settle_cnt_q == 16'd0) begin
                        data_start_c = 1'b1;
                        state_d      = ST_MEASURE;
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
                        wd_cnt_d     = WD_LOAD;
`endif
                    end else begin
                        settle_cnt_d = settle_cnt_q - 16'd1;
                    end
                end
                ST_MEASURE: begin
                    if (freq_ready) begin
                        if (freq_opt) begin
                            state_d = ST_LOCKED;
                        end else begin
                            if (freq_set_up_down != last_dir_q) begin
                                step_d = step_rev;
                                // Only reversals already at the minimum step count
                                // toward convergence.
                                if ((step_q == STEP_MIN) && (rev_cnt_q != 4'd15)) begin
                                    rev_cnt_d = rev_cnt_q + 4'd1;
                                end
                            end
                            last_dir_d = freq_set_up_down;
                            state_d    = ST_STEP;
                        end
                    end
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
                    else if (wd_cnt_q == '0) begin
                        timeout_d    = 1'b1;
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                    end else begin
                        wd_cnt_d = wd_cnt_q - {{(FREQ_W-1){1'b0}}, 1'b1};
                    end
`endif
                end
                ST_STEP: begin
                    if (rev_cnt_q >= REV_LIMIT) begin
                        state_d = ST_LOCKED;
                    end else begin
                        freq_d       = nf_clamped;
                        at_limit_d   = nf_hit_limit;
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                    end
                end
                ST_LOCKED: begin
                    if (freq_ready && !freq_opt) begin
                        step_d       = STEP_INIT;
                        rev_cnt_d    = 4'd0;
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            freq_q       <= F_INIT;
            step_q       <= STEP_INIT;
            last_dir_q   <= 1'b1;
            rev_cnt_q    <= 4'd0;
            settle_cnt_q <= 16'd0;
            at_limit_q   <= 1'b0;
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            freq_q       <= freq_d;
            step_q       <= step_d;
            last_dir_q   <= last_dir_d;
            rev_cnt_q    <= rev_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            at_limit_q   <= at_limit_d;
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign freq       = freq_q;
    assign data_start = data_start_c;
    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) || (state_q == ST_STEP);
    assign locked     = (state_q == ST_LOCKED);
    assign at_limit   = at_limit_q;
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_freq_step_ctrl.sv
// tb/tb_freq_step_ctrl.sv - self-checking bench for freq_step_ctrl
module tb_freq_step_ctrl;

    localparam int SETTLE    = 4;
    localparam int F_MIN     = 30000;
    localparam int F_MAX     = 50000;
    localparam int F_INIT    = 40000;
    localparam int STEP_INIT = 200;
    localparam int STEP_MIN  = 10;
    localparam int REV_LIMIT = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic        freq_ready;
    logic        freq_set_up_down;
    logic        freq_opt;
    logic [19:0] freq;
    logic        data_start;
    logic        busy;
    logic        locked;
    logic        at_limit;
    logic        timeout;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level reference: one entry per tracker decision.
    int mfreq;
    int mstep;
    int mrev;
    bit mdir;
    bit mlocked;
    bit mlim;

    always #5 clk = ~clk;

    freq_step_ctrl #(
        .SETTLE_CYC(16'd4)
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(20'd8)
`endif
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .enable(enable),
        .freq_ready(freq_ready),
        .freq_set_up_down(freq_set_up_down),
        .freq_opt(freq_opt),
        .freq(freq),
        .data_start(data_start),
        .busy(busy),
        .locked(locked),
        .at_limit(at_limit),
        .timeout(timeout)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mfreq   = F_INIT;
        mstep   = STEP_INIT;
        mrev    = 0;
        mdir    = 1'b1;
        mlocked = 1'b0;
        mlim    = 1'b0;
    endtask

    // Called on the first SETTLE cycle; returns on the first MEASURE cycle.
    task automatic do_settle(input bit noise);
        int c;
        int nc;
        c  = 1;
        nc = $urandom_range(1, SETTLE);
        chk("settle_busy", busy, 1);
        forever begin
            if (noise && c == nc) begin
                freq_ready       = 1'b1;
                freq_set_up_down = 1'($urandom);
                freq_opt         = 1'($urandom);
            end
            if (data_start || c >= 3 * SETTLE) break;
            tick();
            freq_ready = 1'b0;
            c++;
        end
        chk("settle_len", c, SETTLE);
        chk("ds_freq", freq, mfreq);
        tick();
        freq_ready = 1'b0;
        chk("ds_single", data_start, 0);
        chk("measure_busy", busy, 1);
    endtask

    // Called in MEASURE or LOCKED; applies one tracker decision.
    task automatic do_result(input bit dir, input bit opt);
        int w;
        int nf;
        w = $urandom_range(0, 3);
        repeat (w) tick();
        freq_ready       = 1'b1;
        freq_set_up_down = dir;
        freq_opt         = opt;
        tick();
        freq_ready = 1'b0;
        if (opt) begin
            mlocked = 1'b1;
            chk("opt_locked", locked, 1);
            chk("opt_busy", busy, 0);
            chk("opt_freq", freq, mfreq);
        end else if (mlocked) begin
            mlocked = 1'b0;
            mstep   = STEP_INIT;
            mrev    = 0;
            chk("loss_locked", locked, 0);
            chk("loss_freq", freq, mfreq);
        end else begin
            if (dir != mdir) begin
                if (mstep == STEP_MIN && mrev < 15) mrev++;
                mstep = (mstep / 2 < STEP_MIN) ? STEP_MIN : mstep / 2;
            end
            mdir = dir;
            chk("step_busy", busy, 1);
            chk("step_hold", freq, mfreq);
            chk("step_ds", data_start, 0);
            tick();
            if (mrev >= REV_LIMIT) begin
                mlocked = 1'b1;
            end else begin
                nf   = dir ? mfreq + mstep : mfreq - mstep;
                mlim = (nf > F_MAX) || (nf < F_MIN);
                if (nf > F_MAX) nf = F_MAX;
                if (nf < F_MIN) nf = F_MIN;
                mfreq = nf;
            end
            chk("new_freq", freq, mfreq);
            chk("new_at_limit", at_limit, mlim);
            chk("new_locked", locked, mlocked);
        end
    endtask

    task automatic transact(input bit dir, input bit opt, input bit noise);
        do_result(dir, opt);
        if (!mlocked) do_settle(noise);
    endtask

    initial begin
        int exp_f[4];
        bit seen_ds;
        exp_f = '{40200, 40400, 40300, 40200};

        nrst = 1'b0; enable = 1'b0; freq_ready = 1'b0;
        freq_set_up_down = 1'b0; freq_opt = 1'b0;
        tick(); tick();
        chk("rst_freq", freq, F_INIT);
        chk("rst_ds", data_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_at_limit", at_limit, 0);
        chk("rst_timeout", timeout, 0);

        nrst = 1'b1;
        tick();
        chk("idle_busy", busy, 0);
        enable = 1'b1;
        tick();
        model_reset();
        do_settle(1'b1);

        // Stepping and halving.
        for (int i = 0; i < 4; i++) begin
            transact((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            chk("halve_freq", freq, exp_f[i]);
        end

        // Lock, hold across further optimum reports, then loss of lock.
        transact(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) transact(1'($urandom), 1'b1, 1'b0);
        chk("lock_hold", freq, 40200);
        do_result(1'b1, 1'b0);

        // Drop enable on the final SETTLE cycle: no data_start, back to IDLE.
        tick(); tick(); tick();
        enable = 1'b0;
        #1;
        chk("drop_ds", data_start, 0);
        tick();
        chk("drop_busy", busy, 0);
        chk("drop_freq", freq, F_INIT);
        chk("drop_timeout", timeout, 0);
        enable = 1'b1;
        tick();
        model_reset();
        do_settle(1'b0);

        // Watchdog.
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
        repeat (7) tick();
        chk("wd_early", timeout, 0);
        tick();
        chk("wd_fired", timeout, 1);
        chk("wd_busy", busy, 1);
        do_settle(1'b0);
`else
        seen_ds = 1'b0;
        repeat (12) begin
            tick();
            seen_ds |= data_start;
        end
        chk("no_wd_ds", seen_ds, 0);
        chk("no_wd_busy", busy, 1);
        chk("no_wd_timeout", timeout, 0);
`endif

        // Upper clamp, then back off; then run down into the lower clamp.
        for (int i = 0; i < 52; i++) transact(1'b1, 1'b0, 1'b0);
        chk("clamp_hi", freq, F_MAX);
        chk("clamp_hi_lim", at_limit, 1);
        transact(1'b0, 1'b0, 1'b0);
        chk("clamp_back", freq, 49900);
`ifdef FREQ_STEP_CTRL_TIMEOUT_EN
        chk("wd_sticky", timeout, 1);
`endif
        for (int i = 0; i < 201; i++) transact(1'b0, 1'b0, 1'b0);
        chk("clamp_lo", freq, F_MIN);
        chk("clamp_lo_lim", at_limit, 1);

        // Convergence: alternate direction until reversals at STEP_MIN lock.
        for (int i = 0; i < 7 && !mlocked; i++) transact((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        chk("conv_locked", locked, 1);
        transact(1'b0, 1'b0, 1'b0);

        // Randomized decisions.
        for (int i = 0; i < 150; i++) begin
            transact(1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
        end

        // Reset mid-operation.
        nrst = 1'b0;
        tick();
        chk("mid_rst_freq", freq, F_INIT);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_lim", at_limit, 0);
        chk("mid_rst_timeout", timeout, 0);
        enable = 1'b0;
        nrst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
